ifetch: RTL

Instruction fetch stage of the single-cycle sun-riscv core. It owns the program counter and issues one request at a time to instruction memory over a variable-latency request/response interface. It holds the returned word stable for the control decoder and datapath until the core signals completion. It then selects the next PC from PC+4 or the ALU target, according to the decoder's PCSel.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_if.sv | 23 ++
 rtl/ifetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch stage: PC select codes, reset
// defaults and the next-PC selection rule.
package ifetch_pkg;

    localparam logic PCSEL_NEXT = 1'b0;
    localparam logic PCSEL_ALU  = 1'b1;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Jump targets always have bit 0 cleared, matching JALR semantics.
    function automatic logic [31:0] select_next_pc(input logic        pcsel,
                                                   input logic [31:0] cur_pc,
                                                   input logic [31:0] alu_target);
        if (pcsel == PCSEL_ALU) begin
            return {alu_target[31:1], 1'b0};
        end
        return cur_pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory request/response bus; one request outstanding at a time.
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time and holds it
// stable until the core retires it, then steps to PC+4 or the ALU target.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSel,
    input  logic [31:0] alu_result,
    input  logic        inst_done,
    ifetch_if.master    imem,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_misaligned,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_TRAP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        inst_valid_reg, inst_valid_next;
    logic        misaligned_reg, misaligned_next;
    logic [31:0] retired_reg, retired_next;
    logic [31:0] target_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= NOP_INST;
            inst_valid_reg <= 1'b0;
            misaligned_reg <= 1'b0;
            retired_reg    <= 32'd0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_reg       <= inst_next;
            inst_valid_reg <= inst_valid_next;
            misaligned_reg <= misaligned_next;
            retired_reg    <= retired_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        inst_valid_next = inst_valid_reg;
        misaligned_next = misaligned_reg;
        retired_next    = retired_reg;
        target_pc       = select_next_pc(PCSel, pc_reg, alu_result);

        unique case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_rvalid) begin
                    inst_next       = imem.imem_rdata;
                    inst_valid_next = 1'b1;
                    state_next      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_done) begin
                    inst_valid_next = 1'b0;
                    inst_next       = NOP_INST;
                    // A target not on a word boundary traps with the PC left
                    // pointing at the offending instruction.
                    if (target_pc[1]) begin
                        misaligned_next = 1'b1;
                        state_next      = ST_TRAP;
                    end else begin
                        pc_next      = target_pc;
                        retired_next = retired_reg + 32'd1;
                        state_next   = ST_FETCH;
                    end
                end
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign imem.imem_req   = (state_reg == ST_FETCH);
    assign imem.imem_addr  = pc_reg;
    assign instruction     = inst_reg;
    assign inst_valid      = inst_valid_reg;
    assign pc              = pc_reg;
    assign pc_plus4        = pc_reg + 32'd4;
    assign fetch_misaligned = misaligned_reg;
    assign retired_count   = retired_reg;

endmodule
